// File: rtl/pht_sram_ctrl_pkg.sv
// Shared types and counter helpers for the pattern-history SRAM controller.
package pht_sram_ctrl_pkg;

  typedef enum logic [3:0] {
    INIT_SETUP,
    INIT_STROBE,
    INIT_HOLD,
    IDLE,
    RD_ADDR,
    RD_SAMPLE,
    RESP,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } state_e;

  localparam int CTR_W_DEF = 2;

  // Weakly-not-taken is the value just below the counter midpoint.
  function automatic int weak_nt(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  function automatic int sat_inc(input int v, input int n);
    return (v >= (1 << n) - 1) ? (1 << n) - 1 : v + 1;
  endfunction

  function automatic int sat_dec(input int v, input int n);
    return (v <= 0) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/pht_sram_ctrl_if.sv
// Predict/update request bus between the branch unit (master) and the PHT controller (slave).
interface pht_sram_ctrl_if #(
  parameter int M = 2,
  parameter int R = 8
);
  // A request transfers on the rising edge where valid and ready are both high; the
  // master holds valid and payload stable until then. pred_resp_valid has no ready.
  logic         pred_valid;
  logic         pred_ready;
  logic [R-1:0] pred_pc_idx;
  logic         pred_resp_valid;
  logic         pred_taken;
  logic [M-1:0] pred_ghr;
  logic         upd_valid;
  logic         upd_ready;
  logic [R-1:0] upd_pc_idx;
  logic [M-1:0] upd_ghr;
  logic         upd_taken;
  logic [M-1:0] ghr;

  modport master (
    output pred_valid, pred_pc_idx, upd_valid, upd_pc_idx, upd_ghr, upd_taken,
    input  pred_ready, pred_resp_valid, pred_taken, pred_ghr, upd_ready, ghr
  );

  modport slave (
    input  pred_valid, pred_pc_idx, upd_valid, upd_pc_idx, upd_ghr, upd_taken,
    output pred_ready, pred_resp_valid, pred_taken, pred_ghr, upd_ready, ghr
  );
endinterface

// File: rtl/pht_sram_ctrl_ctr_next.sv
// Next value of an N-bit saturating counter given the resolved branch outcome.
module pht_ctr_next
  import pht_sram_ctrl_pkg::*;
#(
  parameter int N = CTR_W_DEF
) (
  input  logic [N-1:0] i_ctr,
  input  logic         i_taken,
  output logic [N-1:0] o_next
);

  logic [N-1:0] w_inc;
  logic [N-1:0] w_dec;

  assign w_inc  = N'(sat_inc(int'(i_ctr), N));
  assign w_dec  = N'(sat_dec(int'(i_ctr), N));
  assign o_next = i_taken ? w_inc : w_dec;

endmodule

// File: rtl/pht_sram_ctrl.sv
// Initiator for the async pattern-history SRAM: table clear after reset, predict lookups,
// and read-modify-write counter updates. Owns the global history register.
module pht_sram_ctrl
  import pht_sram_ctrl_pkg::*;
#(
  parameter int M = 2,
  parameter int N = CTR_W_DEF,
  parameter int R = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pht_sram_ctrl_if.slave   bus,
  output logic             sram_cs_n,
  output logic             sram_we_n,
  output logic             sram_oe_n,
  output logic [R+M-1:0]   sram_addr,
  inout  wire  [N-1:0]     sram_data,
  output state_e           o_dbg_state
);

  localparam int           A         = R + M;
  localparam logic [N-1:0] WEAK_NT   = N'(weak_nt(N));
  localparam logic [A-1:0] LAST_ADDR = '1;

  state_e       r_state;
  logic [A-1:0] r_init_addr;
  logic [M-1:0] r_ghr;
  logic         r_cs_n;
  logic         r_we_n;
  logic         r_oe_n;
  logic [A-1:0] r_addr;
  logic [N-1:0] r_wdata;
  logic         r_drive_en;
  logic         r_idle_ready;
  logic         r_resp_valid;
  logic         r_pred_taken;
  logic [M-1:0] r_pred_ghr;
  logic         r_op_taken;
  logic         r_is_upd;

  logic [N-1:0] w_next_ctr;
  logic         w_upd_acc;
  logic         w_pred_acc;

  pht_ctr_next #(.N(N)) u_ctr_next (
    .i_ctr   (sram_data),
    .i_taken (r_op_taken),
    .o_next  (w_next_ctr)
  );

  assign sram_data = r_drive_en ? r_wdata : 'z;

  // Updates win a same-cycle collision so the waiting predict sees the new counter.
  assign bus.upd_ready  = r_idle_ready;
  assign bus.pred_ready = r_idle_ready & ~bus.upd_valid;
  assign w_upd_acc      = r_idle_ready & bus.upd_valid;
  assign w_pred_acc     = bus.pred_ready & bus.pred_valid;

  assign bus.pred_resp_valid = r_resp_valid;
  assign bus.pred_taken      = r_pred_taken;
  assign bus.pred_ghr        = r_pred_ghr;
  assign bus.ghr             = r_ghr;

  assign sram_cs_n   = r_cs_n;
  assign sram_we_n   = r_we_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_addr   = r_addr;
  assign o_dbg_state = r_state;

  // Outputs are loaded on the edge that enters a state, so they always match r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= INIT_SETUP;
      r_init_addr  <= '0;
      r_ghr        <= '0;
      r_cs_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_drive_en   <= 1'b0;
      r_idle_ready <= 1'b0;
      r_resp_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_ghr   <= '0;
      r_op_taken   <= 1'b0;
      r_is_upd     <= 1'b0;
    end else begin
      case (r_state)
        INIT_SETUP: begin
          r_cs_n     <= 1'b0;
          r_we_n     <= 1'b0;
          r_oe_n     <= 1'b1;
          r_addr     <= r_init_addr;
          r_wdata    <= WEAK_NT;
          r_drive_en <= 1'b1;
          r_state    <= INIT_STROBE;
        end
        INIT_STROBE: begin
          r_we_n  <= 1'b1;
          r_state <= INIT_HOLD;
        end
        INIT_HOLD: begin
          if (r_init_addr == LAST_ADDR) begin
            r_cs_n       <= 1'b1;
            r_drive_en   <= 1'b0;
            r_idle_ready <= 1'b1;
            r_state      <= IDLE;
          end else begin
            // Next SETUP already presents the new address with CS asserted.
            r_init_addr <= r_init_addr + 1'b1;
            r_addr      <= r_init_addr + 1'b1;
            r_state     <= INIT_SETUP;
          end
        end
        IDLE: begin
          if (w_upd_acc || w_pred_acc) begin
            r_cs_n       <= 1'b0;
            r_oe_n       <= 1'b0;
            r_we_n       <= 1'b1;
            r_drive_en   <= 1'b0;
            r_idle_ready <= 1'b0;
            r_state      <= RD_ADDR;
          end
          if (w_upd_acc) begin
            r_addr     <= {bus.upd_ghr, bus.upd_pc_idx};
            r_op_taken <= bus.upd_taken;
            r_is_upd   <= 1'b1;
            r_ghr      <= {r_ghr[M-2:0], bus.upd_taken};
          end else if (w_pred_acc) begin
            r_addr   <= {r_ghr, bus.pred_pc_idx};
            r_is_upd <= 1'b0;
          end
        end
        RD_ADDR: begin
          r_state <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          r_oe_n <= 1'b1;
          if (r_is_upd) begin
            r_wdata    <= w_next_ctr;
            r_drive_en <= 1'b1;
            r_state    <= WR_SETUP;
          end else begin
            // GHR cannot move during a predict, so it still equals the value at accept.
            r_cs_n       <= 1'b1;
            r_resp_valid <= 1'b1;
            r_pred_taken <= sram_data[N-1];
            r_pred_ghr   <= r_ghr;
            r_state      <= RESP;
          end
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_idle_ready <= 1'b1;
          r_state      <= IDLE;
        end
        WR_SETUP: begin
          r_we_n  <= 1'b0;
          r_state <= WR_STROBE;
        end
        WR_STROBE: begin
          r_we_n  <= 1'b1;
          r_state <= WR_HOLD;
        end
        WR_HOLD: begin
          r_cs_n       <= 1'b1;
          r_drive_en   <= 1'b0;
          r_idle_ready <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= INIT_SETUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pht_sram_ctrl.sv
// Directed bench for pht_sram_ctrl with an async SRAM model and a predict-response scoreboard.
module tb_pht_sram_ctrl;
  import pht_sram_ctrl_pkg::*;

  localparam int M = 2;
  localparam int N = 2;
  localparam int R = 2;
  localparam int A = R + M;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  pht_sram_ctrl_if #(.M(M), .R(R)) bus ();
  wire  [N-1:0] sram_data;
  logic         sram_cs_n;
  logic         sram_we_n;
  logic         sram_oe_n;
  logic [A-1:0] sram_addr;
  state_e       dbg_state;

  pht_sram_ctrl #(.M(M), .N(N), .R(R)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sram_cs_n   (sram_cs_n),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .sram_addr   (sram_addr),
    .sram_data   (sram_data),
    .o_dbg_state (dbg_state)
  );

  // ---------------- async SRAM model ----------------
  logic [N-1:0] mem [16];
  assign sram_data = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 'z;
  always @(negedge sram_we_n) begin
    #1;
    if (!sram_cs_n && rst_n) mem[sram_addr] = sram_data;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [M:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [M:0] sb_e;
  int         sb_c;

  always @(negedge clk) begin
    if (rst_n && bus.pred_resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        sb_e = exp_q.pop_front();
        sb_c = exp_cyc_q.pop_front();
        check("pred_taken", int'(bus.pred_taken), int'(sb_e[M]));
        check("pred_ghr", int'(bus.pred_ghr), int'(sb_e[M-1:0]));
        check("pred_latency", cyc, sb_c);
      end
    end
  end

  // Write strobe protocol: one low cycle under CS, addr/data stable through HOLD.
  int           we_low = 0;
  logic [A-1:0] cap_addr;
  logic [N-1:0] cap_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      we_low = 0;
    end else if (!sram_we_n) begin
      if (we_low == 0) begin
        cap_addr = sram_addr;
        cap_data = sram_data;
      end
      we_low++;
      check("we_with_cs", int'(sram_cs_n), 0);
      check("we_oe_high", int'(sram_oe_n), 1);
    end else if (we_low != 0) begin
      check("we_pulse_len", we_low, 1);
      check("hold_addr", int'(sram_addr), int'(cap_addr));
      check("hold_data", int'(sram_data), int'(cap_data));
      check("hold_cs", int'(sram_cs_n), 0);
      we_low = 0;
    end else if (!sram_cs_n && !sram_oe_n) begin
      check("rd_bus_value", int'(sram_data), int'(mem[sram_addr]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    #1;
    while (!(bus.upd_ready && exp_q.size() == 0) && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 200) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_init();
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!bus.upd_ready && k < 200);
    check("init_cycles", k, 48);
  endtask

  task automatic do_upd(input logic [R-1:0] pc, input logic [M-1:0] g, input logic t);
    int k = 0;
    @(negedge clk);
    bus.upd_valid  = 1'b1;
    bus.upd_pc_idx = pc;
    bus.upd_ghr    = g;
    bus.upd_taken  = t;
    #1;
    while (!bus.upd_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 100) check("upd_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic push_pred(input logic exp_taken, input logic [M-1:0] exp_ghr);
    exp_q.push_back({exp_taken, exp_ghr});
    exp_cyc_q.push_back(cyc + 3);
  endtask

  task automatic do_pred(input logic [R-1:0] pc, input logic exp_taken, input logic [M-1:0] exp_ghr);
    int k = 0;
    @(negedge clk);
    bus.pred_valid  = 1'b1;
    bus.pred_pc_idx = pc;
    #1;
    while (!bus.pred_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 100) check("pred_ready_timeout", 0, 1);
    push_pred(exp_taken, exp_ghr);
    @(posedge clk);
    #1;
    bus.pred_valid = 1'b0;
  endtask

  task automatic check_all_mem(input int v);
    for (int i = 0; i < 16; i++) check($sformatf("mem[%0d]", i), int'(mem[i[3:0]]), v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, int'(sram_cs_n), 1);
    check({tag, "_we_n"}, int'(sram_we_n), 1);
    check({tag, "_oe_n"}, int'(sram_oe_n), 1);
    check({tag, "_addr"}, int'(sram_addr), 0);
    check({tag, "_ghr"}, int'(bus.ghr), 0);
    check({tag, "_upd_ready"}, int'(bus.upd_ready), 0);
    check({tag, "_pred_ready"}, int'(bus.pred_ready), 0);
    check({tag, "_resp_valid"}, int'(bus.pred_resp_valid), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int low;
    bus.pred_valid  = 1'b0;
    bus.pred_pc_idx = '0;
    bus.upd_valid   = 1'b0;
    bus.upd_pc_idx  = '0;
    bus.upd_ghr     = '0;
    bus.upd_taken   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_pred_taken", int'(bus.pred_taken), 0);
    check("rst_pred_ghr", int'(bus.pred_ghr), 0);

    // Table clear, then a lookup of a fresh entry
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    check_all_mem(1);
    do_pred(2'd3, 1'b0, 2'd0);
    wait_idle();

    // Saturating increment on entry {2,1}=9: 01 -> 10 -> 11 -> 11; ghr 0 -> 1 -> 3 -> 3
    do_upd(2'd1, 2'd2, 1'b1); wait_idle();
    check("e9_after1", int'(mem[9]), 2);
    check("ghr_after1", int'(bus.ghr), 1);
    do_upd(2'd1, 2'd2, 1'b1); wait_idle();
    check("e9_after2", int'(mem[9]), 3);
    do_upd(2'd1, 2'd2, 1'b1); wait_idle();
    check("e9_after3", int'(mem[9]), 3);
    check("ghr_after3", int'(bus.ghr), 3);

    // Same-cycle predict and update on entry {3,3}=15; update wins, predict sees 10
    @(negedge clk);
    bus.upd_valid   = 1'b1;
    bus.upd_pc_idx  = 2'd3;
    bus.upd_ghr     = 2'd3;
    bus.upd_taken   = 1'b1;
    bus.pred_valid  = 1'b1;
    bus.pred_pc_idx = 2'd3;
    #1;
    check("both_upd_ready", int'(bus.upd_ready), 1);
    check("both_pred_ready", int'(bus.pred_ready), 0);
    low = 1;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.pred_ready || low >= 100) break;
      low++;
    end
    check("pred_ready_low_cycles", low, 6);
    push_pred(1'b1, 2'd3);
    @(posedge clk);
    #1;
    bus.pred_valid = 1'b0;
    wait_idle();
    check("e15_after", int'(mem[15]), 2);

    // Saturating decrement on entry 1: 01 -> 00 -> 00; ghr 3 -> 2 -> 0
    do_upd(2'd1, 2'd0, 1'b0); wait_idle();
    check("e1_after1", int'(mem[1]), 0);
    check("ghr_nt1", int'(bus.ghr), 2);
    do_upd(2'd1, 2'd0, 1'b0); wait_idle();
    check("e1_after2", int'(mem[1]), 0);
    check("ghr_nt2", int'(bus.ghr), 0);
    do_pred(2'd1, 1'b0, 2'd0);
    wait_idle();

    // Taken then not-taken from ghr=0 leaves ghr=10; lookup pc=1 then hits entry 9
    do_upd(2'd2, 2'd0, 1'b1); wait_idle();
    check("e2_t", int'(mem[2]), 2);
    check("ghr_t", int'(bus.ghr), 1);
    do_upd(2'd2, 2'd0, 1'b0); wait_idle();
    check("e2_nt", int'(mem[2]), 1);
    check("ghr_tn", int'(bus.ghr), 2);
    do_pred(2'd1, 1'b1, 2'd2);
    wait_idle();

    // Reset while WR_STROBE is on the bus
    @(negedge clk);
    bus.upd_valid  = 1'b1;
    bus.upd_pc_idx = 2'd0;
    bus.upd_ghr    = 2'd0;
    bus.upd_taken  = 1'b1;
    #1;
    check("rst_mid_upd_ready", int'(bus.upd_ready), 1);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("strobe_we_n", int'(sram_we_n), 0);
    check("strobe_state", int'(dbg_state), int'(WR_STROBE));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_e0_written", int'(mem[0]), 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    check_all_mem(1);
    check("post_init_ghr", int'(bus.ghr), 0);

    repeat (4) @(negedge clk);
    check("pending_resp", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
